ramp_dac: RTL and testbench



---
 rtl/ramp_dac.sv | 162 ++++++++++++++++
 tb/tb_ramp_dac.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_dac.sv
// ramp_dac: sequencer for a single-slope column ADC reference ramp.
// Exposure phase drives per-channel bias enables; conversion phase emits a
// saturating digital ramp followed by a one-cycle completion pulse.
// Optional build macro: RAMP_DAC_GRAY_EN adds a registered gray-coded copy
// of the ramp on output ramp_gray.
module ramp_dac #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NBIAS = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             expose,
  input  logic             convert,
  input  logic [WIDTH-1:0] step,
  input  logic [NBIAS-1:0] bias_mask,
  output logic [WIDTH-1:0] ramp_code,
  output logic             ramp_valid,
  output logic [NBIAS-1:0] bias_en,
  output logic             conv_done,
  output logic             busy
`ifdef RAMP_DAC_GRAY_EN
  ,
  output logic [WIDTH-1:0] ramp_gray
`endif
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam logic [WIDTH-1:0] CODE_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [NBIAS-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ramp_code_q, ramp_code_d;
  logic             ramp_valid_q, ramp_valid_d;
  logic [NBIAS-1:0] bias_en_q, bias_en_d;
  logic             conv_done_q, conv_done_d;
  logic             busy_q, busy_d;
  logic [SUM_W-1:0] ramp_sum;
  logic [WIDTH-1:0] ramp_sat;
`ifdef RAMP_DAC_GRAY_EN
  logic [WIDTH-1:0] ramp_gray_q, ramp_gray_d;
`endif

  // Widened add so the ramp clamps at full scale instead of wrapping.
  always_comb begin
    ramp_sum = {1'b0, ramp_code_q} + {1'b0, step_q};
    ramp_sat = ramp_sum[WIDTH] ? CODE_MAX : ramp_sum[WIDTH-1:0];
  end

  // Next state and next registered outputs; outputs default to the idle values.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    mask_d       = mask_q;
    ramp_code_d  = '0;
    ramp_valid_d = 1'b0;
    bias_en_d    = '0;
    conv_done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (expose) begin
          // Expose wins over a simultaneous convert request.
          state_d   = ST_EXPOSE;
          mask_d    = bias_mask;
          bias_en_d = bias_mask;
        end else if (convert) begin
          // A zero step would stall the ramp forever, so it is promoted to 1.
          state_d      = ST_CONVERT;
          step_d       = (step == '0) ? WIDTH'(1) : step;
          ramp_valid_d = 1'b1;
        end
      end
      ST_EXPOSE: begin
        if (expose) begin
          bias_en_d = mask_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        if (!convert) begin
          // Abort: back to idle without a completion pulse.
          state_d = ST_IDLE;
        end else if (ramp_code_q == CODE_MAX) begin
          state_d     = ST_DONE;
          ramp_code_d = CODE_MAX;
          conv_done_d = 1'b1;
        end else begin
          ramp_code_d  = ramp_sat;
          ramp_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        // Always pass through idle so a held convert cannot chain ramps.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

`ifdef RAMP_DAC_GRAY_EN
  // Gray copy derived from the same next value so it stays cycle-aligned.
  always_comb begin
    ramp_gray_d = ramp_code_d ^ (ramp_code_d >> 1);
  end
`endif

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      mask_q       <= '0;
      ramp_code_q  <= '0;
      ramp_valid_q <= 1'b0;
      bias_en_q    <= '0;
      conv_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      mask_q       <= mask_d;
      ramp_code_q  <= ramp_code_d;
      ramp_valid_q <= ramp_valid_d;
      bias_en_q    <= bias_en_d;
      conv_done_q  <= conv_done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef RAMP_DAC_GRAY_EN
  // Gray output register, cleared with the rest of the datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramp_gray_q <= '0;
    end else begin
      ramp_gray_q <= ramp_gray_d;
    end
  end

  assign ramp_gray = ramp_gray_q;
`endif

  assign ramp_code  = ramp_code_q;
  assign ramp_valid = ramp_valid_q;
  assign bias_en    = bias_en_q;
  assign conv_done  = conv_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ramp_dac.sv
// Scoreboard bench for ramp_dac: each stimulus cycle pushes the expected
// post-edge outputs, and the sampler pops and compares them #1 after the edge.
// Honours RAMP_DAC_GRAY_EN for the optional gray output.
module tb_ramp_dac;

  localparam int unsigned W  = 8;
  localparam int unsigned NB = 2;
  localparam logic [W-1:0] MAXC = 8'hFF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          expose;
  logic          convert;
  logic [W-1:0]  step;
  logic [NB-1:0] bias_mask;
  logic [W-1:0]  ramp_code;
  logic          ramp_valid;
  logic [NB-1:0] bias_en;
  logic          conv_done;
  logic          busy;
`ifdef RAMP_DAC_GRAY_EN
  logic [W-1:0]  ramp_gray;
  logic [W-1:0]  prev_gray;
  logic [W-1:0]  prev_code;
  logic          prev_valid;
`endif

  typedef struct {
    logic [W-1:0]  code;
    logic          valid;
    logic [NB-1:0] bias;
    logic          done;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ramp_dac #(.WIDTH(W), .NBIAS(NB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .expose    (expose),
    .convert   (convert),
    .step      (step),
    .bias_mask (bias_mask),
    .ramp_code (ramp_code),
    .ramp_valid(ramp_valid),
    .bias_en   (bias_en),
    .conv_done (conv_done),
    .busy      (busy)
`ifdef RAMP_DAC_GRAY_EN
    ,
    .ramp_gray (ramp_gray)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] c, input logic v, input logic [NB-1:0] b,
                          input logic d, input logic bz);
    exp_t e;
    e.code  = c;
    e.valid = v;
    e.bias  = b;
    e.done  = d;
    e.busy  = bz;
    exp_q.push_back(e);
  endtask

  task automatic exp_idle();
    push_exp('0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic exp_conv(input logic [W-1:0] c);
    push_exp(c, 1'b1, '0, 1'b0, 1'b1);
  endtask

  task automatic exp_done();
    push_exp(MAXC, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic exp_expose(input logic [NB-1:0] b);
    push_exp('0, 1'b0, b, 1'b0, 1'b1);
  endtask

  // Advance one clock and compare the DUT against the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("ramp_code", 32'(ramp_code), 32'(e.code));
      check_eq("ramp_valid", 32'(ramp_valid), 32'(e.valid));
      check_eq("bias_en", 32'(bias_en), 32'(e.bias));
      check_eq("conv_done", 32'(conv_done), 32'(e.done));
      check_eq("busy", 32'(busy), 32'(e.busy));
`ifdef RAMP_DAC_GRAY_EN
      check_eq("ramp_gray", 32'(ramp_gray), 32'(e.code ^ (e.code >> 1)));
      if (e.valid && prev_valid && (e.code == prev_code + W'(1)))
        check_eq("gray_1bit", 32'($countones(ramp_gray ^ prev_gray)), 32'd1);
      prev_gray  = ramp_gray;
      prev_code  = e.code;
      prev_valid = e.valid;
`endif
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_code"}, 32'(ramp_code), 32'd0);
    check_eq({tag, "_valid"}, 32'(ramp_valid), 32'd0);
    check_eq({tag, "_bias"}, 32'(bias_en), 32'd0);
    check_eq({tag, "_done"}, 32'(conv_done), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef RAMP_DAC_GRAY_EN
    check_eq({tag, "_gray"}, 32'(ramp_gray), 32'd0);
`endif
  endtask

  initial begin
    reset_n   = 1'b1;
    expose    = 1'b0;
    convert   = 1'b0;
    step      = '0;
    bias_mask = '0;
`ifdef RAMP_DAC_GRAY_EN
    prev_gray  = '0;
    prev_code  = '0;
    prev_valid = 1'b0;
`endif

    // Reset state.
    #1 reset_n = 1'b0;
    #1 check_all_zero("rst");
    repeat (2) @(posedge clk);
    #1 check_all_zero("rst_hold");
    reset_n = 1'b1;
    exp_idle();
    tick();

    // Full step=1 ramp with convert held through DONE.
    convert = 1'b1;
    step    = 8'd1;
    for (int i = 0; i < 256; i++) begin
      exp_conv(W'(i));
      tick();
    end
    exp_done();
    tick();
    exp_idle();
    tick();
    exp_conv('0);
    tick();
    convert = 1'b0;
    exp_idle();
    tick();

    // step=100 saturates at full scale; step only sampled on entry.
    convert = 1'b1;
    step    = 8'd100;
    exp_conv(8'd0);
    tick();
    step = 8'd3;
    exp_conv(8'd100);
    tick();
    exp_conv(8'd200);
    tick();
    exp_conv(MAXC);
    tick();
    exp_done();
    tick();
    convert = 1'b0;
    exp_idle();
    tick();

    // step=0 behaves as 1; abort at code 50 gives no done pulse.
    convert = 1'b1;
    step    = 8'd0;
    for (int i = 0; i <= 50; i++) begin
      exp_conv(W'(i));
      tick();
    end
    convert = 1'b0;
    exp_idle();
    tick();
    exp_idle();
    tick();

    // Expose has priority; convert ignored while exposing.
    expose    = 1'b1;
    convert   = 1'b1;
    bias_mask = 2'b10;
    exp_expose(2'b10);
    tick();
    bias_mask = 2'b01;
    exp_expose(2'b10);
    tick();
    exp_expose(2'b10);
    tick();
    expose = 1'b0;
    exp_idle();
    tick();
    exp_conv('0);
    tick();
    convert = 1'b0;
    exp_idle();
    tick();

    // Second expose picks up the new mask.
    expose = 1'b1;
    exp_expose(2'b01);
    tick();
    expose = 1'b0;
    exp_idle();
    tick();

    // Asynchronous reset mid-ramp at code 77, then a fresh ramp.
    convert = 1'b1;
    step    = 8'd1;
    for (int i = 0; i <= 77; i++) begin
      exp_conv(W'(i));
      tick();
    end
    #1 reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    #1 reset_n = 1'b1;
    exp_conv(8'd0);
    tick();
    exp_conv(8'd1);
    tick();
    convert = 1'b0;
    exp_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
